// File: rtl/piso_if.sv
// Word-in / bit-out bundle for the parallel-to-serial transmitter.
// master = upstream word source, slave = the serializer itself.
interface piso_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  sout,
    input  sout_valid,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output sout,
    output sout_valid,
    output frame_start,
    output busy
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-word skid register so
// consecutive words stream out with no idle bit between them.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic   clk,
  input logic   rst,
  piso_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             load_pt;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  assign load_pt = (state_q == IDLE) ||
                   (cnt_q == CW'(WIDTH - 1));
  assign accept  = bus.din_valid && !hold_full_q;

  // Bits leave from the output end; zeros fill the vacated end.
  assign shifted = MSB_FIRST ?
                   {shreg_q[WIDTH-2:0], 1'b0} :
                   {1'b0, shreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    unique case (1'b1)
      load_pt && hold_full_q: begin
        shreg_d     = hold_q;
        cnt_d       = '0;
        state_d     = SHIFT;
        hold_full_d = accept;
        if (accept) hold_d = bus.din;
      end
      load_pt && !hold_full_q && accept: begin
        shreg_d = bus.din;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      load_pt && !hold_full_q && !accept: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      !load_pt: begin
        shreg_d = shifted;
        cnt_d   = cnt_q + CW'(1);
        if (accept) begin
          hold_d      = bus.din;
          hold_full_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.din_ready   = !hold_full_q;
  assign bus.sout_valid  = (state_q == SHIFT);
  assign bus.frame_start = (state_q == SHIFT) && (cnt_q == '0);
  assign bus.busy        = (state_q == SHIFT) || hold_full_q;
  assign bus.sout        = (state_q == SHIFT) &&
                           (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4: word width in bits; legal range 2-32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 serialized first, 0 = bit 0 first.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a valid word.
REQ-007 din_ready  output  1  block can accept a word this cycle.
REQ-008 sout  output  1  serial data; drives the d input of the downstream SIPO.
REQ-009 sout_valid  output  1  sout carries a data bit this cycle.
REQ-010 frame_start  output  1  sout carries the first bit of a word this cycle.
REQ-011 busy  output  1  shifter active or holding register occupied.

Function
REQ-012 Storage: one WIDTH-bit shift register, a bit counter (0..WIDTH-1), a one-word holding register with a full flag, and a two-state FSM (IDLE, SHIFT).
REQ-013 Handshake: a word is accepted on a rising edge where din_valid=1 and din_ready=1; din_ready = NOT hold_full, combinational from registers only.
REQ-014 din_valid with din_ready=0: no effect; the upstream holds din stable until acceptance.
REQ-015 Load point: an edge where state=IDLE, or state=SHIFT with counter=WIDTH-1.
REQ-016 At a load point with hold_full=1: shifter loads the holding register, counter reset to 0, state SHIFT; hold_full clears unless a word is accepted on the same edge, in which case that word enters the holding register and hold_full stays 1.
REQ-017 At a load point with hold_full=0 and a word accepted: word bypasses into the shifter, counter reset to 0, state SHIFT, hold_full stays 0.
REQ-018 At a load point with no word available: state goes IDLE.
REQ-019 Not a load point, state=SHIFT, word accepted: word enters the holding register, hold_full set.
REQ-020 In SHIFT, on non-load-point edges: shifter shifts one position toward the output end, counter increments by 1.
REQ-021 sout = shifter MSB if MSB_FIRST=1, else shifter LSB, while state=SHIFT; sout = 0 in IDLE.
REQ-022 Latency: first bit appears on sout in the cycle immediately after the accepting/loading edge; each bit lasts exactly one clock; one word occupies exactly WIDTH cycles.
REQ-023 Back-to-back words: no idle cycle between consecutive words when the next word is available at the load point.
REQ-024 sout_valid = (state=SHIFT); frame_start = (state=SHIFT AND counter=0); busy = (state=SHIFT) OR hold_full.
REQ-025 Sustained throughput: one word per WIDTH cycles; din_ready low while the holding register is occupied.

Reset
REQ-026 rst=1 asynchronously forces state IDLE, counter 0, shifter 0, hold_full 0, without waiting for clk.
REQ-027 During reset: sout=0, sout_valid=0, frame_start=0, busy=0, din_ready=1; words presented while rst=1 are not accepted.
REQ-028 Reset mid-word discards the partial word and any held word; the first accepted word after rst deasserts starts a fresh frame with frame_start=1.

Verification (WIDTH=4, MSB_FIRST=1 unless stated)
REQ-029 Single word 4'b1011 accepted at edge 0 -> sout 1,0,1,1 in cycles 1-4, frame_start=1 only in cycle 1, sout_valid=0 and busy=0 from cycle 5.
REQ-030 4'hA at edge 0 and 4'h5 offered from edge 1 -> contiguous sout 1,0,1,0,0,1,0,1 in cycles 1-8, frame_start in cycles 1 and 5, din_ready=0 in cycles 2-4.
REQ-031 din_valid held high with words A,5,C,3 -> 16 gapless bits, each word accepted exactly once, no word lost or duplicated.
REQ-032 rst pulsed high between clock edges during bit 3 of word 4'hF -> sout, sout_valid and busy drop to 0 immediately; next word 4'h6 emits 0,1,1,0 with frame_start on its first bit.
REQ-033 MSB_FIRST=0, word 4'b0001 -> sout 1,0,0,0.
REQ-034 Loopback: sout to downstream SIPO d, same clk, SIPO reset deasserted -> SIPO parallel output equals 4'hA on the edge after the last bit of word 4'hA.
